wb_stream_mailbox: RTL and testbench

Wishbone classic slave inside `user_project_wrapper`, directly downstream of the management-SoC Wishbone port (`wbs_*`). It bridges host register accesses to a pair of ready/valid streams for user logic. A TX FIFO carries host-written words to user logic. An RX FIFO carries user-logic words back to the host. Status and flush control are memory-mapped.

---
 rtl/wb_stream_mailbox.sv | 115 +++++++++++
 tb/tb_wb_stream_mailbox.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_stream_mailbox.sv
// wb_stream_mailbox: Wishbone classic slave bridging host registers to TX/RX ready/valid FIFOs
module wb_stream_mailbox #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [31:0] ID_VALUE = 32'h4D42_0001
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   tx_mem_q [DEPTH];
  logic [31:0]   rx_mem_q [DEPTH];
  logic [AW-1:0] tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
  logic [AW-1:0] rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          ack_q, tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d, in_ready_q, in_ready_d;
  logic [31:0]   dat_q, dat_d, status;
  logic [1:0]    a;
  logic          accept, wr, rd, tx_empty, tx_full, rx_empty, rx_full;
  logic          tx_push, tx_pop, rx_push, rx_pop, tx_flush, rx_flush;
  logic          unused_ok;

  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

  assign a        = wbs_adr_i[3:2];
  assign accept   = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr       = accept & wbs_we_i;
  assign rd       = accept & ~wbs_we_i;
  assign tx_empty = tx_cnt_q == '0;
  assign tx_full  = tx_cnt_q == FULL;
  assign rx_empty = rx_cnt_q == '0;
  assign rx_full  = rx_cnt_q == FULL;
  assign tx_push  = wr & (a == 2'd0) & ~tx_full;
  assign tx_pop   = ~tx_empty & out_ready;
  assign rx_push  = in_valid & in_ready_q;
  assign rx_pop   = rd & (a == 2'd0) & ~rx_empty;
  assign tx_flush = wr & (a == 2'd2) & wbs_dat_i[0];
  assign rx_flush = wr & (a == 2'd2) & wbs_dat_i[1];
  assign status   = {8'h0, 8'(rx_cnt_q), 8'(tx_cnt_q), 2'b0, rx_unf_q, tx_ovf_q,
                     rx_full, rx_empty, tx_full, tx_empty};

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign out_valid = ~tx_empty;
  assign out_data  = tx_empty ? '0 : tx_mem_q[tx_rd_q];
  assign in_ready  = in_ready_q;

  // Next-state for pointers, counts, sticky flags and read data; flush overrides any handshake
  always_comb begin
    tx_cnt_d   = tx_flush ? '0 : tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    tx_wr_d    = tx_flush ? '0 : tx_wr_q + AW'(tx_push);
    tx_rd_d    = tx_flush ? '0 : tx_rd_q + AW'(tx_pop);
    rx_cnt_d   = rx_flush ? '0 : rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    rx_wr_d    = rx_flush ? '0 : rx_wr_q + AW'(rx_push);
    rx_rd_d    = rx_flush ? '0 : rx_rd_q + AW'(rx_pop);
    in_ready_d = rx_cnt_d < FULL;
    tx_ovf_d   = (wr & (a == 2'd0) & tx_full) | (tx_ovf_q & ~(wr & (a == 2'd1) & wbs_dat_i[4]));
    rx_unf_d   = (rd & (a == 2'd0) & rx_empty) | (rx_unf_q & ~(wr & (a == 2'd1) & wbs_dat_i[5]));
    dat_d      = ~rd ? '0 :
                 (a == 2'd0) ? (rx_empty ? '0 : rx_mem_q[rx_rd_q]) :
                 (a == 2'd1) ? status :
                 (a == 2'd3) ? ID_VALUE : '0;
  end

  // FIFO storage needs no reset; occupancy is tracked by the counters
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= wbs_dat_i;
    if (rx_push) rx_mem_q[rx_wr_q] <= in_data;
  end

  // Control state; reset abandons any in-flight access without an ack
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      tx_rd_q    <= '0;
      tx_wr_q    <= '0;
      tx_cnt_q   <= '0;
      rx_rd_q    <= '0;
      rx_wr_q    <= '0;
      rx_cnt_q   <= '0;
      tx_ovf_q   <= 1'b0;
      rx_unf_q   <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      ack_q      <= accept;
      dat_q      <= dat_d;
      tx_rd_q    <= tx_rd_d;
      tx_wr_q    <= tx_wr_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_rd_q    <= rx_rd_d;
      rx_wr_q    <= rx_wr_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_unf_q   <= rx_unf_d;
      in_ready_q <= in_ready_d;
    end
  end
endmodule

// File: tb/tb_wb_stream_mailbox.sv
// tb_wb_stream_mailbox: randomized bench checking the mailbox against a queue-based model
module tb_wb_stream_mailbox;
  localparam int DEPTH = 16;

  logic        clock = 0, reset_n = 1;
  logic        cyc = 0, stb = 0, we = 0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = 0, dat = 0;
  logic        ack;
  logic [31:0] rdat;
  logic        out_valid, out_ready = 0;
  logic [31:0] out_data;
  logic        in_valid = 0, in_ready;
  logic [31:0] in_data = 0;

  int compared = 0, mismatched = 0;
  bit started = 0;

  wb_stream_mailbox #(.DEPTH(DEPTH), .ID_VALUE(32'h4D42_0001)) dut (
    .clock(clock), .reset_n(reset_n),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: two queues, sticky flags and the ack/read-data the host should see
  logic [31:0] m_txq[$];
  logic [31:0] m_rxq[$];
  bit          m_ack = 0, m_ovf = 0, m_unf = 0, m_rdy = 0, m_acc;
  logic [31:0] m_dat = 0, m_r, m_stat;
  logic [1:0]  m_a;
  int          tn, rn;

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      m_txq.delete(); m_rxq.delete();
      m_ack = 0; m_dat = 0; m_ovf = 0; m_unf = 0; m_rdy = 0;
    end else begin
      m_acc  = cyc && stb && !m_ack;
      m_a    = adr[3:2];
      tn     = m_txq.size();
      rn     = m_rxq.size();
      m_r    = 0;
      m_stat = {8'h0, 8'(rn), 8'(tn), 2'b0, m_unf, m_ovf,
                rn == DEPTH, rn == 0, tn == DEPTH, tn == 0};
      if (m_acc && !we) begin
        if (m_a == 0) begin
          if (rn > 0) m_r = m_rxq.pop_front();
          else m_unf = 1;
        end
        if (m_a == 1) m_r = m_stat;
        if (m_a == 3) m_r = 32'h4D42_0001;
      end
      if (out_ready && tn > 0) void'(m_txq.pop_front());
      if (m_acc && we && m_a == 0) begin
        if (tn < DEPTH) m_txq.push_back(dat);
        else m_ovf = 1;
      end
      if (m_acc && we && m_a == 1) begin
        if (dat[4]) m_ovf = 0;
        if (dat[5]) m_unf = 0;
      end
      if (in_valid && m_rdy) m_rxq.push_back(in_data);
      if (m_acc && we && m_a == 2) begin
        if (dat[0]) m_txq.delete();
        if (dat[1]) m_rxq.delete();
      end
      m_rdy = m_rxq.size() < DEPTH;
      m_ack = m_acc;
      m_dat = m_r;
    end
  end

  // Per-cycle comparison of every output against the model
  initial forever begin
    @(negedge clock);
    if (started) begin
      chk("ack", ack, m_ack);
      chk("wb_dat", rdat, m_dat);
      chk("out_valid", out_valid, m_txq.size() != 0);
      chk("out_data", out_data, m_txq.size() != 0 ? m_txq[0] : 32'h0);
      chk("in_ready", in_ready, m_rdy);
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wb(input logic w, input logic [1:0] a, input logic [31:0] d, output logic [31:0] r);
    bit got = 0;
    cyc = 1; stb = 1; we = w; adr = {28'h0, a, 2'b00}; dat = d; r = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (ack) begin got = 1; r = rdat; end
    end
    if (!got) begin
      compared++; mismatched++;
      $display("FAIL wb_timeout: no ack for adr %0d", a);
    end
    cyc = 0; stb = 0; we = 0;
  endtask

  logic [31:0] r;

  initial begin
    #1 reset_n = 0;
    started = 1;
    repeat (5) step();
    chk("rst_ack", ack, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    reset_n = 1;
    step();
    chk("in_ready_rise", in_ready, 1);
    wb(0, 1, 0, r); chk("status_reset", r, 32'h0000_0005);
    wb(0, 3, 0, r); chk("id", r, 32'h4D42_0001);

    for (int i = 0; i < DEPTH; i++) wb(1, 0, 32'h100 + i, r);
    wb(1, 0, 32'hDEAD, r);
    wb(0, 1, 0, r); chk("status_tx_full", r, 32'h0000_1016);
    out_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_data", out_data, 32'h100 + i);
      step();
    end
    chk("drain_empty", out_valid, 0);
    out_ready = 0;

    for (int k = 0; k < DEPTH; k++) begin
      in_data = 32'hA0 + k; in_valid = 1;
      step();
    end
    chk("in_ready_full", in_ready, 0);
    in_data = 32'hFF;
    repeat (2) step();
    in_valid = 0;
    wb(0, 1, 0, r);
    chk("rx_count", r[23:16], 16);
    chk("rx_full_bit", r[3], 1);
    for (int k = 0; k < DEPTH; k++) begin
      wb(0, 0, 0, r); chk("rx_data", r, 32'hA0 + k);
    end
    wb(0, 0, 0, r); chk("rx_underflow_data", r, 0);
    wb(0, 1, 0, r); chk("sticky_both", r[5:4], 2'b11);
    wb(1, 1, 32'h10, r); wb(0, 1, 0, r); chk("w1c_bit4", r[5:4], 2'b10);
    wb(1, 1, 32'h20, r); wb(0, 1, 0, r); chk("w1c_bit5", r[5:4], 2'b00);

    for (int k = 0; k < 3; k++) begin
      in_data = 32'hC0 + k; in_valid = 1;
      step();
    end
    in_data = 32'hC3;
    cyc = 1; stb = 1; we = 1; adr = 32'h8; dat = 32'h2;
    step();
    in_valid = 0;
    chk("flush_ack", ack, 1);
    cyc = 0; stb = 0; we = 0;
    wb(0, 1, 0, r);
    chk("flush_rx_count", r[23:16], 0);
    chk("flush_rx_empty", r[2], 1);

    for (int it = 0; it < 40; it++) begin
      out_ready = m_txq.size() >= 2;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      wb(1, 0, $urandom, r);
      if (it % 4 == 3) wb(0, 0, 0, r);
    end
    in_valid = 0; out_ready = 1;
    repeat (DEPTH + 2) step();
    out_ready = 0;
    chk("tx_drained", out_valid, 0);

    cyc = 1; stb = 1; we = 0; adr = 32'h4;
    reset_n = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_ack", ack, 0);
    end
    reset_n = 1;
    wb(0, 1, 0, r); chk("retry_status", r, 32'h0000_0005);
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
